// File: rtl/smi_mux.sv
// smi_mux: CM4 SMI to per-channel AXI-stream bridge with a status/control register at address 0.
// SMI strobes, address and data are oversampled into i_clk before any decode.
module smi_mux #(
    parameter int NCHAN  = 2,
    parameter int DW     = 16,
    parameter int LGFIFO = 8,
    parameter int NSYNC  = 2
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_smi_oen,
    input  logic                i_smi_wen,
    input  logic [5:0]          i_smi_sa,
    input  logic [17:0]         i_smi_data,
    output logic [17:0]         o_smi_data,
    output logic                o_smi_oen,
    input  logic [NCHAN-1:0]    S_TX_VALID,
    output logic [NCHAN-1:0]    S_TX_READY,
    input  logic [NCHAN*DW-1:0] S_TX_DATA,
    output logic [NCHAN-1:0]    M_RX_VALID,
    input  logic [NCHAN-1:0]    M_RX_READY,
    output logic [NCHAN*DW-1:0] M_RX_DATA
);
    localparam int DEPTH = 1 << LGFIFO;
    localparam int SW    = DW + 1;  // channel payload plus data bit 16 (badaddr clear)

    if (NCHAN < 1 || NCHAN > 4) begin : g_bad_nchan
        $error("smi_mux: NCHAN must be in 1..4");
    end
    if (DW < 8 || DW > 16) begin : g_bad_dw
        $error("smi_mux: DW must be in 8..16");
    end
    if (NSYNC < 2) begin : g_bad_nsync
        $error("smi_mux: NSYNC must be at least 2");
    end

    logic [NSYNC-1:0] oen_sync_q, wen_sync_q;
    logic             ck_oen_q, last_oen_q, ck_wen_q, last_wen_q;
    logic [5:0]       sa_sync_q  [NSYNC];
    logic [SW-1:0]    dat_sync_q [NSYNC];
    logic [5:0]       ck_sa_q;
    logic [SW-1:0]    ck_dat_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            oen_sync_q <= '1;
            wen_sync_q <= '1;
            ck_oen_q   <= 1'b1;
            last_oen_q <= 1'b1;
            ck_wen_q   <= 1'b1;
            last_wen_q <= 1'b1;
            for (int i = 0; i < NSYNC; i++) begin
                sa_sync_q[i]  <= '0;
                dat_sync_q[i] <= '0;
            end
            ck_sa_q  <= '0;
            ck_dat_q <= '0;
        end else begin
            oen_sync_q    <= {oen_sync_q[NSYNC-2:0], i_smi_oen};
            wen_sync_q    <= {wen_sync_q[NSYNC-2:0], i_smi_wen};
            ck_oen_q      <= oen_sync_q[NSYNC-1];
            last_oen_q    <= ck_oen_q;
            ck_wen_q      <= wen_sync_q[NSYNC-1];
            last_wen_q    <= ck_wen_q;
            sa_sync_q[0]  <= i_smi_sa;
            dat_sync_q[0] <= {i_smi_data[16], i_smi_data[DW-1:0]};
            for (int i = 1; i < NSYNC; i++) begin
                sa_sync_q[i]  <= sa_sync_q[i-1];
                dat_sync_q[i] <= dat_sync_q[i-1];
            end
            ck_sa_q  <= sa_sync_q[NSYNC-1];
            ck_dat_q <= dat_sync_q[NSYNC-1];
        end
    end

    logic wen_rise, oen_rise, oen_fall;
    assign wen_rise = ck_wen_q & ~last_wen_q;
    assign oen_rise = ck_oen_q & ~last_oen_q;
    assign oen_fall = ~ck_oen_q & last_oen_q;

    // Pad stays driven until the read strobe has drained out of every stage.
    assign o_smi_oen = i_smi_oen & (&oen_sync_q) & ck_oen_q & last_oen_q;

    logic [5:0]    wsa_q, rsa_q;
    logic [SW-1:0] wdat_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wsa_q  <= '0;
            wdat_q <= '0;
            rsa_q  <= '0;
        end else begin
            if (!ck_wen_q && !last_wen_q) begin
                wsa_q  <= ck_sa_q;
                wdat_q <= ck_dat_q;
            end
            if (oen_fall) rsa_q <= ck_sa_q;
        end
    end

    function automatic logic [NCHAN-1:0] chan_sel(input logic [5:0] sa);
        logic [NCHAN-1:0] sel;
        sel = '0;
        for (int c = 0; c < NCHAN; c++) sel[c] = (sa == 6'(c + 1));
        return sel;
    endfunction

    logic [NCHAN-1:0] wsel, rsel, csel;
    logic             wstat;
    assign wsel  = chan_sel(wsa_q);
    assign rsel  = chan_sel(rsa_q);
    assign csel  = chan_sel(ck_sa_q);
    assign wstat = (wsa_q == 6'd0);

    // Stream handshakes: a beat transfers on the rising i_clk edge where VALID and READY are both 1;
    // VALID never waits on READY, and READY/VALID here are pure FIFO full/empty flags.
    logic [LGFIFO:0]  rx_wr_q [NCHAN];
    logic [LGFIFO:0]  rx_rd_q [NCHAN];
    logic [LGFIFO:0]  tx_wr_q [NCHAN];
    logic [LGFIFO:0]  tx_rd_q [NCHAN];
    logic [DW-1:0]    rx_mem  [NCHAN][DEPTH];
    logic [DW-1:0]    tx_mem  [NCHAN][DEPTH];
    logic [NCHAN-1:0] rx_full, rx_empty, tx_full, tx_empty;
    logic [NCHAN-1:0] rx_push, rx_pop, tx_push, tx_pop;

    always_comb begin
        rx_full   = '0;
        rx_empty  = '0;
        tx_full   = '0;
        tx_empty  = '0;
        rx_push   = '0;
        rx_pop    = '0;
        tx_push   = '0;
        tx_pop    = '0;
        M_RX_DATA = '0;
        for (int c = 0; c < NCHAN; c++) begin
            rx_empty[c] = (rx_wr_q[c] == rx_rd_q[c]);
            rx_full[c]  = (rx_wr_q[c][LGFIFO] != rx_rd_q[c][LGFIFO]) &&
                          (rx_wr_q[c][LGFIFO-1:0] == rx_rd_q[c][LGFIFO-1:0]);
            tx_empty[c] = (tx_wr_q[c] == tx_rd_q[c]);
            tx_full[c]  = (tx_wr_q[c][LGFIFO] != tx_rd_q[c][LGFIFO]) &&
                          (tx_wr_q[c][LGFIFO-1:0] == tx_rd_q[c][LGFIFO-1:0]);
            rx_push[c]  = wen_rise & wsel[c] & ~rx_full[c];
            rx_pop[c]   = ~rx_empty[c] & M_RX_READY[c];
            tx_push[c]  = S_TX_VALID[c] & ~tx_full[c];
            tx_pop[c]   = oen_rise & rsel[c] & ~tx_empty[c];
            M_RX_DATA[c*DW +: DW] = rx_mem[c][rx_rd_q[c][LGFIFO-1:0]];
        end
    end

    assign M_RX_VALID = ~rx_empty;
    assign S_TX_READY = ~tx_full;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int c = 0; c < NCHAN; c++) begin
                rx_wr_q[c] <= '0;
                rx_rd_q[c] <= '0;
                tx_wr_q[c] <= '0;
                tx_rd_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                if (rx_push[c]) rx_wr_q[c] <= rx_wr_q[c] + 1'b1;
                if (rx_pop[c])  rx_rd_q[c] <= rx_rd_q[c] + 1'b1;
                if (tx_push[c]) tx_wr_q[c] <= tx_wr_q[c] + 1'b1;
                if (tx_pop[c])  tx_rd_q[c] <= tx_rd_q[c] + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int c = 0; c < NCHAN; c++) begin
            if (rx_push[c]) rx_mem[c][rx_wr_q[c][LGFIFO-1:0]] <= wdat_q[DW-1:0];
            if (tx_push[c]) tx_mem[c][tx_wr_q[c][LGFIFO-1:0]] <= S_TX_DATA[c*DW +: DW];
        end
    end

    logic [NCHAN-1:0] ovf_q, ovf_d;
    logic             bad_q, bad_d;

    // Clears are applied first so a same-cycle set wins.
    always_comb begin
        ovf_d = ovf_q;
        bad_d = bad_q;
        if (wen_rise && wstat) begin
            for (int c = 0; c < NCHAN; c++) if (wdat_q[4+c]) ovf_d[c] = 1'b0;
            if (wdat_q[SW-1]) bad_d = 1'b0;
        end
        for (int c = 0; c < NCHAN; c++) if (wen_rise && wsel[c] && rx_full[c]) ovf_d[c] = 1'b1;
        if (wen_rise && !wstat && (wsel == '0)) bad_d = 1'b1;
    end

    logic [17:0] rdata, smi_data_q;

    always_comb begin
        rdata = '0;
        if (ck_sa_q == 6'd0) begin
            for (int c = 0; c < NCHAN; c++) begin
                rdata[c]   = ~tx_empty[c];
                rdata[4+c] = ovf_q[c];
                rdata[8+c] = rx_full[c];
            end
            rdata[16] = bad_q;
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                if (csel[c]) begin
                    rdata[17]     = tx_empty[c];
                    rdata[16]     = rx_full[c];
                    rdata[DW-1:0] = tx_empty[c] ? '1 : tx_mem[c][tx_rd_q[c][LGFIFO-1:0]];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ovf_q      <= '0;
            bad_q      <= 1'b0;
            smi_data_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            bad_q <= bad_d;
            if (!ck_oen_q) smi_data_q <= rdata;
        end
    end

    assign o_smi_data = smi_data_q;

endmodule

// File: tb/tb_smi_mux.sv
// Bench for smi_mux: directed SMI/stream sequences, a vector table and a randomized run
// checked against a queue-based model of the FIFOs and status flags.
module tb_smi_mux;
    localparam int NCH    = 2;
    localparam int DW     = 16;
    localparam int LGF    = 8;
    localparam int NS     = 2;
    localparam int DEPTH  = 1 << LGF;
    localparam int SETTLE = NS + 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              smi_oen = 1'b1;
    logic              smi_wen = 1'b1;
    logic [5:0]        smi_sa = '0;
    logic [17:0]       smi_din = '0;
    logic [17:0]       smi_dout;
    logic              smi_oen_pad;
    logic [NCH-1:0]    s_tx_valid = '0;
    logic [NCH-1:0]    s_tx_ready;
    logic [NCH*DW-1:0] s_tx_data = '0;
    logic [NCH-1:0]    m_rx_valid;
    logic [NCH-1:0]    m_rx_ready = '0;
    logic [NCH*DW-1:0] m_rx_data;

    always #5 clk = ~clk;

    smi_mux #(.NCHAN(NCH), .DW(DW), .LGFIFO(LGF), .NSYNC(NS)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_smi_oen  (smi_oen),
        .i_smi_wen  (smi_wen),
        .i_smi_sa   (smi_sa),
        .i_smi_data (smi_din),
        .o_smi_data (smi_dout),
        .o_smi_oen  (smi_oen_pad),
        .S_TX_VALID (s_tx_valid),
        .S_TX_READY (s_tx_ready),
        .S_TX_DATA  (s_tx_data),
        .M_RX_VALID (m_rx_valid),
        .M_RX_READY (m_rx_ready),
        .M_RX_DATA  (m_rx_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0]  rx_exp_q [NCH][$];
    logic [DW-1:0]  tx_q     [NCH][$];
    logic [NCH-1:0] m_ovf = '0;
    logic           m_bad = 1'b0;

    typedef struct {
        logic [5:0]     wr_sa;
        logic [17:0]    wr_data;
        logic [5:0]     rd_sa;
        logic [17:0]    exp_rd;
        logic [NCH-1:0] exp_valid;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] model_read(input logic [5:0] sa);
        logic [17:0] r;
        int ch;
        r = '0;
        if (sa == 6'd0) begin
            for (int c = 0; c < NCH; c++) begin
                r[c]   = (tx_q[c].size() != 0);
                r[4+c] = m_ovf[c];
                r[8+c] = (rx_exp_q[c].size() == DEPTH);
            end
            r[16] = m_bad;
        end else if (sa <= 6'(NCH)) begin
            ch = int'(sa) - 1;
            r[17] = (tx_q[ch].size() == 0);
            r[16] = (rx_exp_q[ch].size() == DEPTH);
            r[DW-1:0] = (tx_q[ch].size() == 0) ? '1 : tx_q[ch][0];
        end
        return r;
    endfunction

    task automatic model_write(input logic [5:0] sa, input logic [17:0] d);
        int ch;
        if (sa == 6'd0) begin
            for (int c = 0; c < NCH; c++) if (d[4+c]) m_ovf[c] = 1'b0;
            if (d[16]) m_bad = 1'b0;
        end else if (sa <= 6'(NCH)) begin
            ch = int'(sa) - 1;
            if (rx_exp_q[ch].size() == DEPTH) m_ovf[ch] = 1'b1;
            else rx_exp_q[ch].push_back(d[DW-1:0]);
        end else begin
            m_bad = 1'b1;
        end
    endtask

    task automatic smi_write(input logic [5:0] sa, input logic [17:0] d);
        smi_sa  = sa;
        smi_din = d;
        smi_wen = 1'b0;
        repeat (SETTLE) @(negedge clk);
        smi_wen = 1'b1;
        repeat (SETTLE) @(negedge clk);
        model_write(sa, d);
    endtask

    task automatic write_lat(input logic [5:0] sa, input logic [17:0] d, input int ch);
        bit seen;
        seen    = 1'b0;
        smi_sa  = sa;
        smi_din = d;
        smi_wen = 1'b0;
        repeat (SETTLE) @(negedge clk);
        smi_wen = 1'b1;
        for (int i = 1; i <= NS + 3 && !seen; i++) begin
            @(negedge clk);
            if (m_rx_valid[ch]) seen = 1'b1;
        end
        check("wr_latency_valid", 32'(seen), 32'd1);
        check("wr_data", 32'(m_rx_data[ch*DW +: DW]), 32'(d[DW-1:0]));
        repeat (SETTLE) @(negedge clk);
        model_write(sa, d);
    endtask

    task automatic smi_read(input logic [5:0] sa, output logic [17:0] got, output logic [17:0] mexp);
        int ch;
        mexp    = model_read(sa);
        smi_sa  = sa;
        smi_oen = 1'b0;
        repeat (SETTLE) @(negedge clk);
        check("oen_pad_low", 32'(smi_oen_pad), 32'd0);
        got     = smi_dout;
        smi_oen = 1'b1;
        repeat (SETTLE) @(negedge clk);
        check("oen_pad_high", 32'(smi_oen_pad), 32'd1);
        if (sa >= 6'd1 && sa <= 6'(NCH)) begin
            ch = int'(sa) - 1;
            if (tx_q[ch].size() != 0) void'(tx_q[ch].pop_front());
        end
    endtask

    task automatic tx_push(input int ch, input logic [DW-1:0] d);
        check("tx_ready", 32'(s_tx_ready[ch]), 32'(tx_q[ch].size() < DEPTH));
        s_tx_valid[ch] = 1'b1;
        s_tx_data[ch*DW +: DW] = d;
        @(negedge clk);
        s_tx_valid[ch] = 1'b0;
        if (tx_q[ch].size() < DEPTH) tx_q[ch].push_back(d);
    endtask

    task automatic rx_pop(input int ch);
        check("rx_valid", 32'(m_rx_valid[ch]), 32'(rx_exp_q[ch].size() != 0));
        if (rx_exp_q[ch].size() != 0)
            check("rx_data", 32'(m_rx_data[ch*DW +: DW]), 32'(rx_exp_q[ch][0]));
        m_rx_ready[ch] = 1'b1;
        @(negedge clk);
        m_rx_ready[ch] = 1'b0;
        if (rx_exp_q[ch].size() != 0) void'(rx_exp_q[ch].pop_front());
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] got, mexp;
        int          ch;
        logic [5:0]  sa;

        vecs[0] = '{6'd7,  18'h00000, 6'd0, 18'h10000, 2'b00};
        vecs[1] = '{6'd0,  18'h00000, 6'd0, 18'h10000, 2'b00};
        vecs[2] = '{6'd0,  18'h10000, 6'd0, 18'h00000, 2'b00};
        vecs[3] = '{6'd1,  18'h0ABCD, 6'd1, 18'h2FFFF, 2'b01};
        vecs[4] = '{6'd2,  18'h05A5A, 6'd2, 18'h2FFFF, 2'b11};
        vecs[5] = '{6'd63, 18'h3FFFF, 6'd0, 18'h10000, 2'b11};
        vecs[6] = '{6'd3,  18'h01234, 6'd0, 18'h10000, 2'b11};
        vecs[7] = '{6'd0,  18'h3FFFF, 6'd0, 18'h00000, 2'b11};

        repeat (3) @(negedge clk);
        check("rst_rx_valid", 32'(m_rx_valid), 32'd0);
        check("rst_tx_ready", 32'(s_tx_ready), 32'(2'b11));
        check("rst_oen_pad", 32'(smi_oen_pad), 32'd1);
        check("rst_smi_data", 32'(smi_dout), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write latency and channel steering
        write_lat(6'd1, 18'h01234, 0);
        check("other_valid_low", 32'(m_rx_valid[1]), 32'd0);
        write_lat(6'd2, 18'h0BEEF, 1);
        rx_pop(0);
        rx_pop(1);
        check("rx_drained", 32'(m_rx_valid), 32'd0);

        foreach (vecs[i]) begin
            smi_write(vecs[i].wr_sa, vecs[i].wr_data);
            check("vec_rx_valid", 32'(m_rx_valid), 32'(vecs[i].exp_valid));
            smi_read(vecs[i].rd_sa, got, mexp);
            check("vec_read", 32'(got), 32'(vecs[i].exp_rd));
        end
        rx_pop(0);
        rx_pop(1);

        // TX channel read pops once, then reads as empty
        tx_push(1, 16'h00A5);
        smi_read(6'd2, got, mexp);
        check("tx_read_data", 32'(got), 32'h000A5);
        smi_read(6'd2, got, mexp);
        check("tx_read_empty", 32'(got), 32'h2FFFF);

        // STATUS read does not pop
        tx_push(0, 16'h1111);
        smi_read(6'd0, got, mexp);
        check("status_tx_nonempty", 32'(got), 32'h00001);
        smi_read(6'd0, got, mexp);
        check("status_no_pop", 32'(got), 32'h00001);
        smi_read(6'd1, got, mexp);
        check("tx0_read", 32'(got), 32'h01111);
        smi_read(6'd1, got, mexp);
        check("tx0_empty", 32'(got), 32'h2FFFF);

        // RX overflow and W1C
        for (int i = 0; i <= DEPTH; i++) smi_write(6'd1, 18'(i));
        smi_read(6'd0, got, mexp);
        check("ovf_status", 32'(got), 32'h00110);
        smi_read(6'd1, got, mexp);
        check("ovf_chan_read", 32'(got), 32'h3FFFF);
        smi_write(6'd0, 18'h00010);
        smi_read(6'd0, got, mexp);
        check("ovf_cleared", 32'(got), 32'h00100);
        for (int i = 0; i < DEPTH; i++) rx_pop(0);
        check("ovf_last_dropped", 32'(m_rx_valid[0]), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0: begin
                    sa = 6'($urandom_range(0, 7));
                    smi_write(sa, 18'($urandom_range(0, 18'h3FFFF)));
                end
                1: begin
                    sa = 6'($urandom_range(0, NCH));
                    smi_read(sa, got, mexp);
                    check("rand_read", 32'(got), 32'(mexp));
                end
                2: begin
                    ch = int'($urandom_range(0, NCH - 1));
                    if (tx_q[ch].size() < 8) tx_push(ch, DW'($urandom_range(0, 16'hFFFF)));
                end
                default: rx_pop(int'($urandom_range(0, NCH - 1)));
            endcase
        end
        for (int c = 0; c < NCH; c++) while (rx_exp_q[c].size() != 0) rx_pop(c);

        // Reset in the middle of a write
        smi_write(6'd2, 18'h07777);
        tx_push(0, 16'h4242);
        check("pre_rst_valid", 32'(m_rx_valid[1]), 32'd1);
        smi_sa  = 6'd1;
        smi_din = 18'h0DEAD;
        smi_wen = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("midrst_rx_valid", 32'(m_rx_valid), 32'd0);
        check("midrst_tx_ready", 32'(s_tx_ready), 32'(2'b11));
        check("midrst_oen_pad", 32'(smi_oen_pad), 32'd1);
        check("midrst_smi_data", 32'(smi_dout), 32'd0);
        @(negedge clk);
        smi_wen = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            rx_exp_q[c].delete();
            tx_q[c].delete();
        end
        m_ovf = '0;
        m_bad = 1'b0;
        repeat (2 * SETTLE) @(negedge clk);
        check("postrst_no_push", 32'(m_rx_valid), 32'd0);
        smi_read(6'd0, got, mexp);
        check("postrst_status", 32'(got), 32'h00000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
